// File: rtl/arm_position_tracker_if.sv
// Register-bus bundle for arm_position_tracker: tri-state data and size lines plus address/rw/select.
interface arm_position_tracker_if;
    wire  [31:0] databus;
    wire  [2:0]  reg_size;
    logic [7:0]  register_addr;
    logic        rw;
    logic        select;

    modport master (
        inout  databus,
        input  reg_size,
        output register_addr,
        output rw,
        output select
    );

    modport slave (
        inout  databus,
        output reg_size,
        input  register_addr,
        input  rw,
        input  select
    );
endinterface

// File: rtl/arm_position_tracker.sv
// Single-axis step position tracker with debounced limit-switch homing and register-bus access.
// Optional software travel limits are compiled in when ARM_TRACK_SOFTLIM_EN is defined.
module arm_position_tracker #(
    parameter logic [7:0]  axis_haddr      = 8'h00,
    parameter int unsigned debounce_cycles = 12000
) (
    input  logic                  clk_12MHz,
    input  logic                  resetn,
    input  logic                  step_line,
    input  logic                  steppol,
    input  logic                  dir,
    input  logic                  en,
    input  logic                  limitn,
    arm_position_tracker_if.slave bus,
    output logic                  pause
);
    localparam int unsigned     DB_W    = (debounce_cycles > 1) ? $clog2(debounce_cycles) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(debounce_cycles - 1);

    localparam logic [7:0] OFF_CONTROL  = 8'd0;
    localparam logic [7:0] OFF_STATUS   = 8'd1;
    localparam logic [7:0] OFF_POSITION = 8'd2;
`ifdef ARM_TRACK_SOFTLIM_EN
    localparam logic [7:0] OFF_SOFT_MIN = 8'd3;
    localparam logic [7:0] OFF_SOFT_MAX = 8'd4;
`endif

    localparam logic signed [31:0] POS_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] POS_MIN = 32'sh8000_0000;

    typedef enum logic [1:0] {
        HOME_IDLE,
        HOME_ARMED,
        HOME_HIT
    } home_state_t;

    home_state_t home_q, home_next;

    logic              rst_meta_n, rst_n;
    logic              step_int;
    logic [2:0]        step_sync;
    logic [1:0]        dir_sync;
    logic [1:0]        limn_sync;
    logic [2:0]        sel_sync;
    logic              step_rise, count_step, dir_s, limit_pressed_s;
    logic [DB_W-1:0]   db_cnt;
    logic              limit, limit_d, limit_rise;
    logic [7:0]        offset;
    logic [31:0]       wdata;
    logic              wr_evt, wr_ctrl, wr_pos, clear;
    logic              ctrl_softlim, ctrl_home_arm;
    logic              homed, home_zero;
    logic signed [31:0] position, pos_next;
    logic              hit_min, hit_max, at_min, at_max;
    logic [31:0]       rd_data, rd_data_q;
    logic [2:0]        rd_size, rd_size_q;

    // Asynchronous assert, synchronous release for everything in the clk_12MHz domain.
    always_ff @(posedge clk_12MHz or negedge resetn) begin
        if (!resetn) begin
            rst_meta_n <= 1'b0;
            rst_n      <= 1'b0;
        end else begin
            rst_meta_n <= 1'b1;
            rst_n      <= rst_meta_n;
        end
    end

    assign step_int = step_line ^ ~steppol;

    always_ff @(posedge clk_12MHz or negedge rst_n) begin
        if (!rst_n) begin
            step_sync <= '0;
            dir_sync  <= '0;
            limn_sync <= '1;
            sel_sync  <= '0;
        end else begin
            step_sync <= {step_sync[1:0], step_int};
            dir_sync  <= {dir_sync[0], dir};
            limn_sync <= {limn_sync[0], limitn};
            sel_sync  <= {sel_sync[1:0], bus.select};
        end
    end

    assign step_rise       = step_sync[1] & ~step_sync[2];
    assign count_step      = step_rise & ~en;
    assign dir_s           = dir_sync[1];
    assign limit_pressed_s = ~limn_sync[1];

    // Address, rw and data are held stable by the master while select is high.
    assign offset  = bus.register_addr - axis_haddr;
    assign wdata   = bus.databus;
    assign wr_evt  = sel_sync[1] & ~sel_sync[2] & ~bus.rw;
    assign wr_ctrl = wr_evt && (offset == OFF_CONTROL);
    assign wr_pos  = wr_evt && (offset == OFF_POSITION);
    assign clear   = wr_ctrl & wdata[2];

    always_ff @(posedge clk_12MHz or negedge rst_n) begin
        if (!rst_n) begin
            limit   <= 1'b0;
            limit_d <= 1'b0;
            db_cnt  <= '0;
        end else begin
            limit_d <= limit;
            if (limit_pressed_s != limit) begin
                if (db_cnt == DB_LAST) begin
                    limit  <= limit_pressed_s;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign limit_rise = limit & ~limit_d;

    always_ff @(posedge clk_12MHz or negedge rst_n) begin
        if (!rst_n) begin
            home_q <= HOME_IDLE;
        end else begin
            home_q <= home_next;
        end
    end

    always_comb begin
        home_next = home_q;
        home_zero = 1'b0;
        case (home_q)
            HOME_IDLE: begin
                if (wr_ctrl && wdata[1]) begin
                    home_next = HOME_ARMED;
                end
            end
            HOME_ARMED: begin
                if (wr_ctrl && !wdata[1]) begin
                    home_next = HOME_IDLE;
                end else if (limit_rise) begin
                    home_next = HOME_HIT;
                    home_zero = 1'b1;
                end
            end
            HOME_HIT: begin
                if (wr_ctrl && !wdata[1]) begin
                    home_next = HOME_IDLE;
                end
            end
            default: home_next = HOME_IDLE;
        endcase
    end

    always_ff @(posedge clk_12MHz or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_softlim  <= 1'b0;
            ctrl_home_arm <= 1'b0;
            homed         <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_softlim  <= wdata[0];
                ctrl_home_arm <= wdata[1];
            end
            if (clear) begin
                homed <= 1'b0;
            end else if (home_zero) begin
                homed <= 1'b1;
            end
        end
    end

    // Lower-priority sources are dropped when a higher one fires in the same cycle.
    always_comb begin
        pos_next = position;
        if (clear) begin
            pos_next = '0;
        end else if (wr_pos) begin
            pos_next = $signed(wdata);
        end else if (home_zero) begin
            pos_next = '0;
        end else if (count_step) begin
            if (dir_s) begin
                if (position != POS_MAX) pos_next = position + 32'sd1;
            end else begin
                if (position != POS_MIN) pos_next = position - 32'sd1;
            end
        end
    end

    always_ff @(posedge clk_12MHz or negedge rst_n) begin
        if (!rst_n) begin
            position <= '0;
        end else begin
            position <= pos_next;
        end
    end

`ifdef ARM_TRACK_SOFTLIM_EN
    logic signed [31:0] soft_min, soft_max;

    always_ff @(posedge clk_12MHz or negedge rst_n) begin
        if (!rst_n) begin
            soft_min <= POS_MIN;
            soft_max <= POS_MAX;
        end else begin
            if (wr_evt && (offset == OFF_SOFT_MIN)) soft_min <= $signed(wdata);
            if (wr_evt && (offset == OFF_SOFT_MAX)) soft_max <= $signed(wdata);
        end
    end

    assign hit_max = ctrl_softlim && (position >= soft_max);
    assign hit_min = ctrl_softlim && (position <= soft_min);
`else
    assign hit_max = 1'b0;
    assign hit_min = 1'b0;
`endif

    // Raw dir steers pause so reversing away from a limit releases it on the next clock.
    always_ff @(posedge clk_12MHz or negedge rst_n) begin
        if (!rst_n) begin
            at_min <= 1'b0;
            at_max <= 1'b0;
            pause  <= 1'b0;
        end else begin
            at_min <= hit_min;
            at_max <= hit_max;
            pause  <= (hit_max & dir) | (hit_min & ~dir) | (home_next == HOME_HIT);
        end
    end

    always_comb begin
        rd_data = '0;
        rd_size = '0;
        case (offset)
            OFF_CONTROL: begin
                rd_data = {30'd0, ctrl_home_arm, ctrl_softlim};
                rd_size = 3'd1;
            end
            OFF_STATUS: begin
                rd_data = {28'd0, limit, at_max, at_min, homed};
                rd_size = 3'd1;
            end
            OFF_POSITION: begin
                rd_data = position;
                rd_size = 3'd4;
            end
`ifdef ARM_TRACK_SOFTLIM_EN
            OFF_SOFT_MIN: begin
                rd_data = soft_min;
                rd_size = 3'd4;
            end
            OFF_SOFT_MAX: begin
                rd_data = soft_max;
                rd_size = 3'd4;
            end
`endif
            default: begin
                rd_data = '0;
                rd_size = '0;
            end
        endcase
    end

    // Read data is captured directly on the select edge and held for the whole access.
    always_ff @(posedge bus.select or negedge resetn) begin
        if (!resetn) begin
            rd_data_q <= '0;
            rd_size_q <= '0;
        end else begin
            rd_data_q <= rd_data;
            rd_size_q <= rd_size;
        end
    end

    assign bus.databus  = (bus.select && bus.rw) ? rd_data_q : 'z;
    assign bus.reg_size = bus.select ? rd_size_q : 'z;

endmodule

// File: tb/tb_arm_position_tracker.sv
// Directed bench for arm_position_tracker: step counting, soft limits, homing, debounce and bus priority.
module tb_arm_position_tracker;
    logic        clk_12MHz = 1'b0;
    logic        resetn;
    logic        step_line;
    logic        steppol;
    logic        dir;
    logic        en;
    logic        limitn;
    logic        pause;
    logic        tb_drv;
    logic [31:0] tb_wdata;
    logic [31:0] rd_val;
    logic [2:0]  rd_sz;
    int          n_checks = 0;
    int          n_errors = 0;

    arm_position_tracker_if bus ();

    assign bus.databus = tb_drv ? tb_wdata : 'z;

    arm_position_tracker #(
        .axis_haddr      (8'h00),
        .debounce_cycles (12000)
    ) dut (
        .clk_12MHz (clk_12MHz),
        .resetn    (resetn),
        .step_line (step_line),
        .steppol   (steppol),
        .dir       (dir),
        .en        (en),
        .limitn    (limitn),
        .bus       (bus),
        .pause     (pause)
    );

    always #5 clk_12MHz = ~clk_12MHz;

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_12MHz);
    endtask

    task automatic do_step();
        step_line = steppol;
        tick(4);
        step_line = ~steppol;
        tick(4);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) do_step();
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [31:0] data);
        bus.register_addr = addr;
        bus.rw            = 1'b0;
        tb_wdata          = data;
        tb_drv            = 1'b1;
        #1;
        bus.select = 1'b1;
        tick(4);
        bus.select = 1'b0;
        tb_drv     = 1'b0;
        bus.rw     = 1'b1;
        tick(2);
    endtask

    task automatic bus_read(input logic [7:0] addr, output logic [31:0] data, output logic [2:0] size);
        bus.register_addr = addr;
        bus.rw            = 1'b1;
        #1;
        bus.select = 1'b1;
        #2;
        data = bus.databus;
        size = bus.reg_size;
        tick(1);
        bus.select = 1'b0;
        tick(1);
    endtask

    task automatic check_reg(input string tag, input logic [7:0] addr,
                             input logic [31:0] exp_data, input logic [2:0] exp_size);
        bus_read(addr, rd_val, rd_sz);
        check({tag, " data"}, rd_val, exp_data);
        check({tag, " size"}, {29'd0, rd_sz}, {29'd0, exp_size});
    endtask

    initial begin
        resetn            = 1'b0;
        steppol           = 1'b1;
        step_line         = 1'b0;
        dir               = 1'b1;
        en                = 1'b0;
        limitn            = 1'b1;
        tb_drv            = 1'b0;
        tb_wdata          = '0;
        bus.select        = 1'b0;
        bus.rw            = 1'b1;
        bus.register_addr = 8'h00;
        tick(3);
        resetn = 1'b1;
        tick(4);

        check("reset pause", {31'd0, pause}, 32'd0);
        check_reg("reset position", 8'h02, 32'd0, 3'd4);
        check_reg("reset control", 8'h00, 32'd0, 3'd1);
        check_reg("reset status", 8'h01, 32'd0, 3'd1);

        dir = 1'b1;
        steps(10);
        dir = 1'b0;
        tick(2);
        steps(3);
        check_reg("up10 down3", 8'h02, 32'd7, 3'd4);

        en = 1'b1;
        dir = 1'b1;
        steps(5);
        en = 1'b0;
        tick(2);
        check_reg("disabled steps", 8'h02, 32'd7, 3'd4);

        steppol   = 1'b0;
        step_line = 1'b1;
        tick(2);
        steps(4);
        check_reg("inverted polarity", 8'h02, 32'd11, 3'd4);
        steppol   = 1'b1;
        step_line = 1'b0;
        tick(2);

`ifdef ARM_TRACK_SOFTLIM_EN
        check_reg("soft_min reset", 8'h03, 32'h8000_0000, 3'd4);
        bus_write(8'h04, 32'd100);
        bus_write(8'h02, 32'd98);
        bus_write(8'h00, 32'd1);
        check_reg("soft_max", 8'h04, 32'd100, 3'd4);
        do_step();
        check("pause below max", {31'd0, pause}, 32'd0);
        step_line = 1'b1;
        tick(3);
        check("pause same clock as 100", {31'd0, pause}, 32'd0);
        tick(1);
        check("pause at max", {31'd0, pause}, 32'd1);
        step_line = 1'b0;
        tick(4);
        check_reg("status at max", 8'h01, 32'h4, 3'd1);
        dir = 1'b0;
        tick(1);
        check("pause released by reverse", {31'd0, pause}, 32'd0);
        bus_write(8'h00, 32'd0);
        dir = 1'b1;
        tick(2);
`else
        check_reg("soft_max unmapped", 8'h04, 32'd0, 3'd0);
        bus_write(8'h04, 32'd5);
        bus_write(8'h00, 32'd1);
        check_reg("softlim bit r/w", 8'h00, 32'd1, 3'd1);
        do_step();
        check("no soft pause", {31'd0, pause}, 32'd0);
        check_reg("status no at flags", 8'h01, 32'd0, 3'd1);
        check_reg("soft_max still unmapped", 8'h04, 32'd0, 3'd0);
        bus_write(8'h00, 32'd0);
`endif

        bus_write(8'h02, 32'd500);
        check_reg("position write 500", 8'h02, 32'd500, 3'd4);
        bus_write(8'h00, 32'd2);
        check_reg("home_arm set", 8'h00, 32'd2, 3'd1);
        limitn = 1'b0;
        tick(12002);
        check("pause before hit", {31'd0, pause}, 32'd0);
        tick(1);
        check("pause at hit", {31'd0, pause}, 32'd1);
        check_reg("homed position", 8'h02, 32'd0, 3'd4);
        check_reg("status homed+limit", 8'h01, 32'h9, 3'd1);
        bus_write(8'h00, 32'd0);
        check("pause after disarm", {31'd0, pause}, 32'd0);
        check_reg("control disarmed", 8'h00, 32'd0, 3'd1);
        limitn = 1'b1;
        tick(12005);
        check_reg("status limit released", 8'h01, 32'h1, 3'd1);

        bus_write(8'h02, 32'd77);
        bus_write(8'h00, 32'd2);
        limitn = 1'b0;
        tick(11999);
        limitn = 1'b1;
        tick(20);
        check_reg("glitch status", 8'h01, 32'h1, 3'd1);
        check("glitch pause", {31'd0, pause}, 32'd0);
        check_reg("glitch position", 8'h02, 32'd77, 3'd4);
        limitn = 1'b0;
        tick(12005);
        check("still armed after glitch", {31'd0, pause}, 32'd1);
        check_reg("rehome position", 8'h02, 32'd0, 3'd4);
        bus_write(8'h00, 32'd0);
        check("pause after second disarm", {31'd0, pause}, 32'd0);

        bus_write(8'h02, 32'd33);
        bus_write(8'h00, 32'd4);
        check_reg("clear position", 8'h02, 32'd0, 3'd4);
        check_reg("clear reads 0", 8'h00, 32'd0, 3'd1);
        check_reg("clear drops homed", 8'h01, 32'h8, 3'd1);
        limitn = 1'b1;

        bus_write(8'h02, 32'd10);
        dir               = 1'b1;
        bus.register_addr = 8'h02;
        bus.rw            = 1'b0;
        tb_wdata          = 32'd42;
        tb_drv            = 1'b1;
        step_line         = steppol;
        #1;
        bus.select = 1'b1;
        tick(4);
        bus.select = 1'b0;
        tb_drv     = 1'b0;
        bus.rw     = 1'b1;
        step_line  = ~steppol;
        tick(4);
        check_reg("write beats step", 8'h02, 32'd42, 3'd4);

        bus_write(8'h02, 32'h7FFF_FFFF);
        do_step();
        check_reg("saturate max", 8'h02, 32'h7FFF_FFFF, 3'd4);
        dir = 1'b0;
        tick(2);
        do_step();
        check_reg("step down from max", 8'h02, 32'h7FFF_FFFE, 3'd4);
        bus_write(8'h02, 32'h8000_0000);
        do_step();
        check_reg("saturate min", 8'h02, 32'h8000_0000, 3'd4);

        check_reg("unmapped 0x10", 8'h10, 32'd0, 3'd0);
        check_reg("unmapped 0x05", 8'h05, 32'd0, 3'd0);
        bus_write(8'h10, 32'd5);
        check_reg("unmapped write ignored", 8'h02, 32'h8000_0000, 3'd4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/arm_position_tracker.md
# arm_position_tracker

Single-axis step position tracker sitting directly downstream of the arm axis control peripheral. Consumes the peripheral's step/direction/enable outputs plus the axis limit switch, and keeps a signed absolute step count. Also runs a limit-switch homing sequence and, optionally, software travel limits. Its `pause` output feeds back into the peripheral's `pause` input. Exposes its registers on the shared uniboard register bus.

## Interface
- `axis_haddr`, 8'h00: base address of this instance's five registers.
- `debounce_cycles`, 12000: limit-switch stable cycles required (1 ms at 12 MHz).
- `clk_12MHz` in 1: system clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `step_line` in 1: peripheral step output (polarity per `steppol`).
- `steppol` in 1: copy of peripheral config STEPPOL bit.
- `dir` in 1: 1 = positive travel, 0 = negative.
- `en` in 1: driver enable, active-low; steps are counted only while low.
- `limitn` in 1: limit switch, active-low, asynchronous.
- `databus` inout 32: register bus data.
- `reg_size` out (tri) 3: byte size of the addressed register.
- `register_addr` in 8: register address.
- `rw` in 1: 0 = write, 1 = read.
- `select` in 1: rising edge writes; held high to read.
- `pause` out 1: registered; high requests the peripheral to stop stepping.

## Operation
- Registers (offset from `axis_haddr`):
  - +0 CONTROL, 1 byte, r/w. Bit0 SOFTLIM_EN; bit1 HOME_ARM; bit2 CLEAR (self-clearing, reads 0).
  - +1 STATUS, 1 byte, ro. Bit0 HOMED; bit1 AT_MIN; bit2 AT_MAX; bit3 LIMIT (debounced, high = pressed).
  - +2 POSITION, 4 bytes, r/w, signed.
  - +3 SOFT_MIN, 4 bytes, r/w, signed.
  - +4 SOFT_MAX, 4 bytes, r/w, signed.
  - Unmapped addresses read 0 with size 0; writes to them are ignored.
- Step recovery:
  - Internal step = `step_line` XOR ~`steppol`.
  - Internal step, `dir` and `limitn` each pass through a 2-flop synchronizer.
  - Each rising edge of synchronized internal step while `en`=0 counts +1 (`dir`=1) or -1 (`dir`=0).
  - POSITION saturates at 32'h7FFFFFFF / 32'h80000000; no wrap.
- Limit debounce: LIMIT changes only after the synchronized `limitn` holds a new value for `debounce_cycles` consecutive cycles.
- Homing FSM:
  - IDLE: HOME_ARM written 1 -> ARMED.
  - ARMED: LIMIT rises -> HIT. POSITION <= 0, HOMED <= 1, steps arriving that cycle are dropped.
  - HIT: `pause` held. HOME_ARM written 0 -> IDLE.
  - HOME_ARM written 0 in ARMED -> IDLE with no other effect.
- Soft limits (SOFTLIM_EN=1):
  - AT_MAX = POSITION >= SOFT_MAX; AT_MIN = POSITION <= SOFT_MIN (signed compares).
  - `pause` = (AT_MAX & `dir`) | (AT_MIN & ~`dir`) | (FSM==HIT).
  - Travel away from the violated limit is never paused.
- Bus:
  - Read value and size are latched on `select` rising edge.
  - `databus` is driven only while `select`&`rw`; `reg_size` only while `select`; both are 'z otherwise.
  - A write is detected as the rising edge of `select` sampled in `clk_12MHz`, with `rw`=0.
- Simultaneous events, priority highest first: CLEAR > POSITION write > homing zero > counted step.
  - The losing step is dropped, not deferred.
  - CLEAR zeroes POSITION and HOMED only.
- Reset (asynchronous assert, synchronous release):
  - POSITION=0, CONTROL=0, HOMED=0, FSM=IDLE, `pause`=0, LIMIT=0, debounce counter=0.
  - SOFT_MIN=32'h80000000, SOFT_MAX=32'h7FFFFFFF.
  - Reset mid-homing aborts to IDLE.

## Timing
- `step_line` edge to POSITION update: 3 clocks (2 sync + edge detect).
- POSITION change to `pause`/AT_* update: 1 clock.
- `limitn` change to LIMIT: 2 + `debounce_cycles` clocks. LIMIT to HIT and POSITION=0: 1 clock.
- Register write takes effect 3 clocks after `select` rises (2 sync + edge).
- Minimum step period tracked reliably: 4 clocks high + 4 clocks low.

## Configuration
- `ARM_TRACK_SOFTLIM_EN` defined: SOFT_MIN/SOFT_MAX, AT_MIN/AT_MAX and soft-limit `pause` terms are compiled in.
- Undefined: those registers are unmapped (read 0, size 0, writes ignored), and AT_MIN/AT_MAX read 0. SOFTLIM_EN remains r/w but has no effect; `pause` = (FSM==HIT) only.

## Test plan
- Reset, then 10 steps with `dir`=1, `en`=0, then 3 steps with `dir`=0 -> POSITION reads 7, size 4.
- 5 steps with `en`=1 -> POSITION unchanged; `steppol`=0 with inverted `step_line` -> same counts as `steppol`=1.
- SOFT_MAX=100, SOFTLIM_EN=1, step up from 98 -> `pause`=1 one clock after POSITION=100. Set `dir`=0 -> `pause`=0 next clock.
- HOME_ARM=1 at POSITION=500, assert `limitn`=0 for 12002+ cycles -> POSITION=0, HOMED=1, `pause`=1. Write HOME_ARM=0 -> `pause`=0.
- `limitn` glitch of 11999 cycles -> LIMIT stays 0, FSM stays ARMED.
- POSITION write of 42 coincident with a counted step -> reads 42. POSITION=32'h7FFFFFFF plus a +1 step -> stays 32'h7FFFFFFF.
